// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl
// Game-flow controller for the pong display. It steps through four phases:
// new game, play, new ball and game over. It holds the current score, the
// high score and the count of balls left in reserve. It also chooses which
// text overlay regions are enabled, and it freezes the graphics engine
// between rallies.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   btn[1:0]   player buttons (level); any bit high means "pressed"
//   tick       one-cycle pulse per video frame
//   hit        one-cycle pulse: ball returned by a paddle
//   miss       one-cycle pulse: ball left the field
//   dig0/dig1  current score, BCD ones/tens
//   dig2/dig3  high score, BCD ones/tens
//   ball[1:0]  balls remaining in reserve
//   text_en    overlay region enables {score, logo, rule, over}
//   gra_still  1 = graphics frozen, ball parked
//   state[1:0] current phase: 0 NEWGAME, 1 PLAY, 2 NEWBALL, 3 OVER
module pong_game_ctrl #(
  parameter int BALLS       = 3,
  parameter int TIMER_TICKS = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  input  logic       tick,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [1:0] ball,
  output logic [3:0] text_en,
  output logic       gra_still,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    ST_NEWGAME = 2'd0,
    ST_PLAY    = 2'd1,
    ST_NEWBALL = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam logic [1:0] BALLS_L = 2'(BALLS);
  localparam logic [7:0] TIMER_L = 8'(TIMER_TICKS);

  // Two-digit BCD increment. It saturates at 99.
  function automatic logic [7:0] bcd_inc_sat(input logic [7:0] s);
    logic [7:0] r;
    if (s == 8'h99)          r = s;
    else if (s[3:0] == 4'd9) r = {s[7:4] + 4'd1, 4'd0};
    else                     r = {s[7:4], s[3:0] + 4'd1};
    return r;
  endfunction

  // Overlay mask for each phase: {score, logo, rule, over}.
  function automatic logic [3:0] phase_text_en(input state_t s);
    logic [3:0] m;
    case (s)
      ST_NEWGAME: m = 4'b1110;
      ST_OVER:    m = 4'b1101;
      default:    m = 4'b1000;
    endcase
    return m;
  endfunction

  function automatic logic phase_still(input state_t s);
    return (s != ST_PLAY);
  endfunction

  state_t     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [7:0] high_q,  high_d;
  logic [1:0] ball_q,  ball_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] text_en_q, text_en_d;
  logic       gra_still_q, gra_still_d;
  logic [7:0] score_post;
  logic       btn_pressed;

  assign btn_pressed = |btn;

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    ball_d     = ball_q;
    timer_d    = timer_q;
    // The hit is applied first, so the high-score compare in a
    // same-cycle hit+miss uses the score after the hit.
    score_post = hit ? bcd_inc_sat(score_q) : score_q;

    case (state_q)
      ST_NEWGAME: begin
        if (btn_pressed) begin
          state_d = ST_PLAY;
          ball_d  = BALLS_L - 2'd1;
        end
      end
      ST_PLAY: begin
        score_d = score_post;
        if (miss) begin
          timer_d = TIMER_L;
          if (ball_q != 2'd0) begin
            state_d = ST_NEWBALL;
            ball_d  = ball_q - 2'd1;
          end else begin
            state_d = ST_OVER;
            if (score_post > high_q) high_d = score_post;
          end
        end
      end
      ST_NEWBALL: begin
        if (timer_q == 8'd0) begin
          if (btn_pressed) state_d = ST_PLAY;
        end else if (tick) begin
          timer_d = timer_q - 8'd1;
        end
      end
      default: begin // ST_OVER
        if (timer_q == 8'd0) begin
          state_d = ST_NEWGAME;
          score_d = 8'h00;
          ball_d  = BALLS_L;
        end else if (tick) begin
          timer_d = timer_q - 8'd1;
        end
      end
    endcase

    // These are decoded from the next state and registered, so they
    // change on the same edge as state and cannot glitch.
    text_en_d   = phase_text_en(state_d);
    gra_still_d = phase_still(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_NEWGAME;
      score_q     <= 8'h00;
      high_q      <= 8'h00;
      ball_q      <= BALLS_L;
      timer_q     <= 8'd0;
      text_en_q   <= 4'b1110;
      gra_still_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      high_q      <= high_d;
      ball_q      <= ball_d;
      timer_q     <= timer_d;
      text_en_q   <= text_en_d;
      gra_still_q <= gra_still_d;
    end
  end

  assign dig0      = score_q[3:0];
  assign dig1      = score_q[7:4];
  assign dig2      = high_q[3:0];
  assign dig3      = high_q[7:4];
  assign ball      = ball_q;
  assign text_en   = text_en_q;
  assign gra_still = gra_still_q;
  assign state     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] btn;
  logic       tick, hit, miss;
  logic [3:0] dig0, dig1, dig2, dig3;
  logic [1:0] ball;
  logic [3:0] text_en;
  logic       gra_still;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  pong_game_ctrl #(.BALLS(3), .TIMER_TICKS(120)) dut (
    .clk(clk), .reset(reset), .btn(btn), .tick(tick), .hit(hit), .miss(miss),
    .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3), .ball(ball),
    .text_en(text_en), .gra_still(gra_still), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic hit_n(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; cyc(); hit = 1'b0;
    end
  endtask

  // Each tick pulse is followed by one idle cycle.
  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; cyc(); tick = 1'b0; cyc();
    end
  endtask

  task automatic press();
    btn = 2'b01; cyc(); btn = 2'b00;
  endtask

  task automatic miss_pulse();
    miss = 1'b1; cyc(); miss = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".state"}, {6'd0, state}, 8'd0);
    chk({tag, ".score"}, {dig1, dig0}, 8'h00);
    chk({tag, ".high"},  {dig3, dig2}, 8'h00);
    chk({tag, ".ball"},  {6'd0, ball}, 8'd3);
    chk({tag, ".still"}, {7'd0, gra_still}, 8'd1);
    chk({tag, ".text"},  {4'd0, text_en}, 8'b1110);
  endtask

  // Full game: use both reserve balls, then end on a hit+miss with
  // final score = final.
  task automatic play_game(input int final_score);
    press();
    for (int b = 0; b < 2; b++) begin
      miss_pulse();
      tick_n(120);
      press();
    end
    hit_n(final_score - 1);
    hit = 1'b1; miss = 1'b1; cyc(); hit = 1'b0; miss = 1'b0;
  endtask

  initial begin
    reset = 1'b1; btn = 2'b00; tick = 1'b0; hit = 1'b0; miss = 1'b0;
    cyc(); cyc();
    reset = 1'b0;
    check_reset_vals("rst");

    // Start the game.
    press();
    chk("start.state", {6'd0, state}, 8'd1);
    chk("start.ball",  {6'd0, ball}, 8'd2);
    chk("start.still", {7'd0, gra_still}, 8'd0);
    chk("start.text",  {4'd0, text_en}, 8'b1000);

    // Score counting and saturation.
    hit_n(12);
    chk("score12", {dig1, dig0}, 8'h12);
    hit_n(87);
    chk("score99", {dig1, dig0}, 8'h99);
    hit_n(1);
    chk("score_sat", {dig1, dig0}, 8'h99);

    // Miss with reserve, then a held button through the pause.
    miss_pulse();
    chk("nb.state", {6'd0, state}, 8'd2);
    chk("nb.ball",  {6'd0, ball}, 8'd1);
    chk("nb.still", {7'd0, gra_still}, 8'd1);
    btn = 2'b10;
    tick_n(119);
    chk("nb.t119", {6'd0, state}, 8'd2);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("nb.t120", {6'd0, state}, 8'd2);
    cyc();
    chk("nb.resume", {6'd0, state}, 8'd1);
    btn = 2'b00;

    // Fresh start, so the high score is zero again.
    reset = 1'b1; cyc(); reset = 1'b0;
    check_reset_vals("rst2");

    // Hit/miss in NEWGAME are ignored.
    hit = 1'b1; miss = 1'b1; cyc(); hit = 1'b0; miss = 1'b0;
    chk("ng.ignore.state", {6'd0, state}, 8'd0);
    chk("ng.ignore.score", {dig1, dig0}, 8'h00);

    // Game ending 07 plus a simultaneous hit: the high score becomes 08.
    play_game(8);
    chk("ov.state", {6'd0, state}, 8'd3);
    chk("ov.high",  {dig3, dig2}, 8'h08);
    chk("ov.score", {dig1, dig0}, 8'h08);
    chk("ov.text",  {4'd0, text_en}, 8'b1101);
    chk("ov.still", {7'd0, gra_still}, 8'd1);
    hit = 1'b1; miss = 1'b1; btn = 2'b11; cyc(); hit = 1'b0; miss = 1'b0; btn = 2'b00;
    chk("ov.ignore.score", {dig1, dig0}, 8'h08);
    chk("ov.ignore.state", {6'd0, state}, 8'd3);
    tick_n(120);
    chk("ng2.state", {6'd0, state}, 8'd0);
    chk("ng2.score", {dig1, dig0}, 8'h00);
    chk("ng2.ball",  {6'd0, ball}, 8'd3);
    chk("ng2.high",  {dig3, dig2}, 8'h08);
    chk("ng2.text",  {4'd0, text_en}, 8'b1110);

    // An equal score does not update the high score.
    play_game(8);
    chk("eq.high", {dig3, dig2}, 8'h08);
    tick_n(120);
    // A higher score does.
    play_game(9);
    chk("gt.high", {dig3, dig2}, 8'h09);
    tick_n(120);
    chk("gt.state", {6'd0, state}, 8'd0);

    // Reset in the middle of a pause, with 50 ticks still to go.
    press();
    hit_n(3);
    miss_pulse();
    tick_n(70);
    chk("mid.state", {6'd0, state}, 8'd2);
    reset = 1'b1; tick = 1'b1; btn = 2'b01; cyc();
    reset = 1'b0; tick = 1'b0; btn = 2'b00;
    check_reset_vals("rst_mid");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1, "timeout");
  end

endmodule
